// File: rtl/hex_conv_ctrl.sv
// rtl/hex_conv_ctrl.sv - binary to five-digit BCD converter, one double-dabble step per clock
//
// Purpose:
//   Converts a WIDTH-bit operand (4..16) to five BCD digits with a fixed
//   latency of WIDTH+1 cycles. A DONE state allows back-to-back starts.
//   Optional macro HEX_CONV_SIGNED_EN: operand is two's complement, and the
//   magnitude is converted with sign reported separately. Without it the
//   operand is unsigned and sign is tied to 1.
//
// Ports:
//   clk                      rising-edge clock
//   reset                    asynchronous active-low reset
//   start                    convert request, sampled only while ready=1
//   h_number[WIDTH-1:0]      operand, captured on the accepting edge
//   ready                    start will be accepted on the next edge (IDLE/DONE)
//   busy                     conversion iterations in progress (CONV)
//   done                     one-cycle pulse, new digits valid (DONE)
//   D_one..D_five[3:0]       registered BCD digits, D_one least significant
//   sign                     1 = non-negative, 0 = negative

module hex_conv_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] h_number,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [3:0]       D_one,
  output logic [3:0]       D_two,
  output logic [3:0]       D_three,
  output logic [3:0]       D_four,
  output logic [3:0]       D_five,
  output logic             sign
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic             r_ready;
  logic             r_busy;
  logic             r_done;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_operand;
  logic [19:0]      r_bcd;
  logic [19:0]      r_digits;

  logic [WIDTH-1:0] w_mag;
  logic [19:0]      w_adj;
  logic [19:0]      w_step;

`ifdef HEX_CONV_SIGNED_EN
  logic             r_sign_pend;
  logic             r_sign;
  logic             w_sign_in;

  // Negation in WIDTH bits maps the most negative value onto 2^(WIDTH-1),
  // which is exactly the unsigned magnitude we want.
  assign w_mag     = h_number[WIDTH-1] ? (~h_number + WIDTH'(1)) : h_number;
  assign w_sign_in = ~h_number[WIDTH-1];
  assign sign      = r_sign;
`else
  assign w_mag = h_number;
  assign sign  = 1'b1;
`endif

  // Double-dabble step: add 3 to each digit >= 5, then shift in the operand MSB.
  always_comb begin
    w_adj = r_bcd;
    for (int i = 0; i < 5; i++) begin
      if (r_bcd[4*i +: 4] >= 4'd5) begin
        w_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
      end
    end
  end

  // Carry out of the top digit is dropped; it cannot occur for WIDTH <= 16.
  assign w_step = {w_adj[18:0], r_operand[WIDTH-1]};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_ready   <= 1'b1;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_count   <= '0;
      r_operand <= '0;
      r_bcd     <= '0;
      r_digits  <= '0;
`ifdef HEX_CONV_SIGNED_EN
      r_sign_pend <= 1'b1;
      r_sign      <= 1'b1;
`endif
    end else begin
      case (r_state)
        IDLE, DONE: begin
          r_done <= 1'b0;
          if (start) begin
            r_state   <= CONV;
            r_ready   <= 1'b0;
            r_busy    <= 1'b1;
            r_operand <= w_mag;
            r_bcd     <= '0;
            r_count   <= CW'(WIDTH - 1);
`ifdef HEX_CONV_SIGNED_EN
            r_sign_pend <= w_sign_in;
`endif
          end else begin
            r_state <= IDLE;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
          end
        end

        CONV: begin
          r_bcd     <= w_step;
          r_operand <= r_operand << 1;
          if (r_count == '0) begin
            // Final step: publish the result on the same edge.
            r_state  <= DONE;
            r_ready  <= 1'b1;
            r_busy   <= 1'b0;
            r_done   <= 1'b1;
            r_digits <= w_step;
`ifdef HEX_CONV_SIGNED_EN
            r_sign <= r_sign_pend;
`endif
          end else begin
            r_count <= r_count - CW'(1);
          end
        end

        default: begin
          r_state <= IDLE;
          r_ready <= 1'b1;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign ready   = r_ready;
  assign busy    = r_busy;
  assign done    = r_done;
  assign D_one   = r_digits[3:0];
  assign D_two   = r_digits[7:4];
  assign D_three = r_digits[11:8];
  assign D_four  = r_digits[15:12];
  assign D_five  = r_digits[19:16];

endmodule

// File: tb/tb_hex_conv_ctrl.sv
// tb/tb_hex_conv_ctrl.sv - self-checking bench for hex_conv_ctrl

module tb_hex_conv_ctrl;

  localparam int WIDTH = 16;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [WIDTH-1:0] h_number;
  logic             ready;
  logic             busy;
  logic             done;
  logic [3:0]       D_one;
  logic [3:0]       D_two;
  logic [3:0]       D_three;
  logic [3:0]       D_four;
  logic [3:0]       D_five;
  logic             sign;

  int n_checks = 0;
  int n_fail   = 0;

  logic [19:0] dig;
  assign dig = {D_five, D_four, D_three, D_two, D_one};

  hex_conv_ctrl #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .h_number (h_number),
    .ready    (ready),
    .busy     (busy),
    .done     (done),
    .D_one    (D_one),
    .D_two    (D_two),
    .D_three  (D_three),
    .D_four   (D_four),
    .D_five   (D_five),
    .sign     (sign)
  );

  always #5 clk = ~clk;

  // Reference: decimal digits by division, {sign, D_five..D_one}.
  function automatic logic [20:0] ref_model(input logic [15:0] v);
    int          mag;
    logic        s;
    logic [19:0] d;
    mag = int'(v);
    s   = 1'b1;
`ifdef HEX_CONV_SIGNED_EN
    if (v[15]) begin
      mag = 65536 - int'(v);
      s   = 1'b0;
    end
`endif
    for (int i = 0; i < 5; i++) begin
      d[4*i +: 4] = 4'(mag % 10);
      mag = mag / 10;
    end
    return {s, d};
  endfunction

  // Presents v at a negedge; the following posedge is the accepting edge.
  task automatic launch(input logic [15:0] v);
    @(negedge clk);
    start    = 1'b1;
    h_number = v;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Counts edges after the accepting edge until done is seen (-1 on timeout).
  // conv_ok drops if any in-flight cycle shows wrong handshake or moving outputs.
  task automatic wait_done(output int cycles, output bit conv_ok, input bit toggle);
    logic [19:0] held_dig;
    logic        held_sign;
    held_dig  = dig;
    held_sign = sign;
    conv_ok   = 1'b1;
    cycles    = -1;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (done === 1'b1) begin
        cycles = n;
        break;
      end
      if (busy !== 1'b1 || ready !== 1'b0 || dig !== held_dig || sign !== held_sign)
        conv_ok = 1'b0;
      if (toggle) begin
        start    = 1'($urandom);
        h_number = 16'($urandom);
      end
    end
  endtask

  task automatic test_reset;
    reset    = 1'b0;
    start    = 1'b0;
    h_number = '0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({ready, busy, done, sign, dig} !== {1'b1, 1'b0, 1'b0, 1'b1, 20'h0}) begin
      n_fail++;
      $display("FAIL reset_state: got rdy=%b busy=%b done=%b sign=%b dig=%h, want 1 0 0 1 00000",
               ready, busy, done, sign, dig);
    end
    reset = 1'b1;
  endtask

  task automatic test_basic;
    int cyc;
    bit ok;
    launch(16'd12345);
    n_checks++;
    if (busy !== 1'b1 || ready !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_enter_conv: busy=%b ready=%b, want 1 0", busy, ready);
    end
    wait_done(cyc, ok, 1'b0);
    n_checks++;
    if (cyc !== WIDTH) begin
      n_fail++;
      $display("FAIL basic_latency: done after %0d edges, want %0d", cyc, WIDTH);
    end
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL basic_conv_hold: got handshake/output change during CONV, want stable");
    end
    n_checks++;
    if (dig !== 20'h12345 || sign !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_digits: got %h sign %b, want 12345 sign 1", dig, sign);
    end
    @(negedge clk);
    n_checks++;
    if (done !== 1'b0 || ready !== 1'b1 || busy !== 1'b0 || dig !== 20'h12345) begin
      n_fail++;
      $display("FAIL basic_after_done: done=%b ready=%b busy=%b dig=%h, want 0 1 0 12345",
               done, ready, busy, dig);
    end
  endtask

  task automatic test_corners;
    logic [15:0] vals [3];
    logic [20:0] exps [3];
    int cyc;
    bit ok;
`ifdef HEX_CONV_SIGNED_EN
    vals[0] = 16'hFFFF; exps[0] = {1'b0, 20'h00001};
    vals[1] = 16'h8000; exps[1] = {1'b0, 20'h32768};
    vals[2] = 16'h7FFF; exps[2] = {1'b1, 20'h32767};
`else
    vals[0] = 16'hFFFF; exps[0] = {1'b1, 20'h65535};
    vals[1] = 16'h0000; exps[1] = {1'b1, 20'h00000};
    vals[2] = 16'h8000; exps[2] = {1'b1, 20'h32768};
`endif
    for (int i = 0; i < 3; i++) begin
      launch(vals[i]);
      wait_done(cyc, ok, 1'b0);
      n_checks++;
      if (cyc !== WIDTH || {sign, dig} !== exps[i]) begin
        n_fail++;
        $display("FAIL corner_%h: got lat %0d sign %b dig %h, want lat %0d sign %b dig %h",
                 vals[i], cyc, sign, dig, WIDTH, exps[i][20], exps[i][19:0]);
      end
    end
  endtask

  task automatic test_back_to_back;
    int c1, c2;
    bit ok1, ok2;
    @(negedge clk);
    start    = 1'b1;
    h_number = 16'd100;
    @(posedge clk);
    @(negedge clk);
    h_number = 16'd999;
    wait_done(c1, ok1, 1'b0);
    n_checks++;
    if (c1 !== WIDTH || !ok1 || dig !== 20'h00100 || ready !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_first: lat %0d ok %b dig %h ready %b, want lat %0d ok 1 dig 00100 ready 1",
               c1, ok1, dig, ready, WIDTH);
    end
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    n_checks++;
    if (busy !== 1'b1 || ready !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_no_idle: busy=%b ready=%b done=%b, want 1 0 0", busy, ready, done);
    end
    wait_done(c2, ok2, 1'b0);
    n_checks++;
    if (c2 + 1 !== WIDTH + 1 || !ok2 || dig !== 20'h00999) begin
      n_fail++;
      $display("FAIL b2b_second: pulse spacing %0d ok %b dig %h, want spacing %0d ok 1 dig 00999",
               c2 + 1, ok2, dig, WIDTH + 1);
    end
  endtask

  task automatic test_ignore_start;
    logic [15:0] v;
    logic [20:0] e;
    int cyc;
    bit ok;
    for (int i = 0; i < 3; i++) begin
      v = 16'($urandom);
      e = ref_model(v);
      launch(v);
      wait_done(cyc, ok, 1'b1);
      start = 1'b0;
      n_checks++;
      if (cyc !== WIDTH || !ok || {sign, dig} !== e) begin
        n_fail++;
        $display("FAIL ignore_start_%h: lat %0d ok %b sign %b dig %h, want lat %0d ok 1 sign %b dig %h",
                 v, cyc, ok, sign, dig, WIDTH, e[20], e[19:0]);
      end
    end
  endtask

  task automatic test_random;
    logic [15:0] v;
    logic [20:0] e;
    int cyc;
    bit ok;
    for (int i = 0; i < 16; i++) begin
      v = 16'($urandom);
      e = ref_model(v);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      launch(v);
      wait_done(cyc, ok, 1'b0);
      n_checks++;
      if (cyc !== WIDTH || !ok || {sign, dig} !== e) begin
        n_fail++;
        $display("FAIL random_%h: lat %0d ok %b sign %b dig %h, want lat %0d ok 1 sign %b dig %h",
                 v, cyc, ok, sign, dig, WIDTH, e[20], e[19:0]);
      end
    end
  endtask

  task automatic test_reset_abort;
    int cyc;
    bit ok;
    bit seen_done;
    launch(16'd54321);
    repeat (7) @(negedge clk);
    reset = 1'b0;
    #1;
    n_checks++;
    if ({ready, busy, done, sign, dig} !== {1'b1, 1'b0, 1'b0, 1'b1, 20'h0}) begin
      n_fail++;
      $display("FAIL abort_outputs: rdy=%b busy=%b done=%b sign=%b dig=%h, want 1 0 0 1 00000",
               ready, busy, done, sign, dig);
    end
    @(negedge clk);
    reset = 1'b1;
    seen_done = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) seen_done = 1'b1;
    end
    n_checks++;
    if (seen_done) begin
      n_fail++;
      $display("FAIL abort_no_done: got done/busy after reset, want none");
    end
    launch(16'd7);
    wait_done(cyc, ok, 1'b0);
    n_checks++;
    if (cyc !== WIDTH || !ok || dig !== 20'h00007 || sign !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_restart: lat %0d ok %b dig %h sign %b, want lat %0d ok 1 dig 00007 sign 1",
               cyc, ok, dig, sign, WIDTH);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_corners();
    test_back_to_back();
    test_ignore_start();
    test_random();
    test_reset_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
